// File: rtl/sys_defs_pkg.sv
// Shared definitions for the completion/CDB cluster (package sys_defs).
// Holds the default machine widths, the CDB and FU-done packet layouts used
// by the ROB / map table side, and the `N_FU / `CDB_QDEPTH style macros that
// older files still reference.
// Ports: none (package only).

`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef N_FU
`define N_FU 4
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif
`ifndef CDB_QDEPTH
`define CDB_QDEPTH 2
`endif

package sys_defs;

  localparam int DEF_N_WAY    = `N_WAY;
  localparam int DEF_N_FU     = `N_FU;
  localparam int DEF_CDB_BITS = `CDB_BITS;
  localparam int DEF_QDEPTH   = `CDB_QDEPTH;
  localparam int DEF_XLEN     = 32;

  typedef struct packed {
    logic                    valid;
    logic [DEF_CDB_BITS-1:0] tag;
    logic [DEF_XLEN-1:0]     value;
  } CDB_PACKET;

  typedef struct packed {
    logic                    valid;
    logic [DEF_CDB_BITS-1:0] tag;
    logic [DEF_XLEN-1:0]     result;
  } FU_DONE_PACKET;

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: one DEPTH-entry FIFO buffering finished results of a single FU.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-low reset
//   push, din     enqueue din (ignored when full)
//   pop           dequeue head (ignored when empty)
//   flush         empty the FIFO at the edge; wins over push/pop
//   full, empty   status from the registered count only
//   head          oldest entry (contents undefined while empty)

module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 38
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/complete_stage.sv
// complete_stage: completion / CDB arbiter feeding the ROB, map table and
// free list. Each FU has its own cdb_fifo; up to N_WAY non-empty FIFOs are
// granted per cycle in round-robin order starting at rr_ptr and broadcast
// unlatched on the CDB slots.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   fu_valid/tag/result per-FU finished result (tag 0 is never enqueued)
//   fu_stall            per-FU FIFO full, FU must hold its result
//   branch_haz          mispredict flush: blanks the CDB, clears all FIFOs
//   complete_valid/dest_tag/value   N_WAY broadcast slots, zero when idle
// Optional: define COMPLETE_PERF_EN to add perf_bcast_cnt (valid slots
// broadcast) and perf_stall_cnt (cycles with any stalled fu_valid).

module complete_stage
  import sys_defs::*;
#(
  parameter int N_WAY    = DEF_N_WAY,
  parameter int N_FU     = DEF_N_FU,
  parameter int CDB_BITS = DEF_CDB_BITS,
  parameter int XLEN     = DEF_XLEN,
  parameter int QDEPTH   = DEF_QDEPTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [N_FU-1:0]                    fu_valid,
  input  logic [N_FU-1:0][CDB_BITS-1:0]      fu_tag,
  input  logic [N_FU-1:0][XLEN-1:0]          fu_result,
  output logic [N_FU-1:0]                    fu_stall,
  input  logic                               branch_haz,
  output logic [N_WAY-1:0]                   complete_valid,
  output logic [N_WAY-1:0][CDB_BITS-1:0]     complete_dest_tag,
  output logic [N_WAY-1:0][XLEN-1:0]         complete_value
`ifdef COMPLETE_PERF_EN
  ,
  output logic [31:0]                        perf_bcast_cnt,
  output logic [31:0]                        perf_stall_cnt
`endif
);

  localparam int FU_W = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int EW   = CDB_BITS + XLEN;

  logic [N_FU-1:0]               push, pop, full, empty;
  logic [N_FU-1:0][EW-1:0]       head;
  logic [FU_W-1:0]               rr_ptr, rr_next, last_win, idx;
  logic [N_WAY-1:0]              slot_busy;
  logic [N_WAY-1:0][FU_W-1:0]    slot_fu;
  logic                          any_win;

  assign fu_stall = full;

  for (genvar i = 0; i < N_FU; i++) begin : g_fu
    // Stall comes from the registered count, so a same-cycle pop never
    // opens room for a refill; zero tags are dropped at the door.
    assign push[i] = fu_valid[i] && !full[i] && !branch_haz && (fu_tag[i] != '0);

    cdb_fifo #(.DEPTH(QDEPTH), .WIDTH(EW)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .flush (branch_haz),
      .din   ({fu_tag[i], fu_result[i]}),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );

    a_no_valid_when_stalled: assert property (
      @(posedge clock) disable iff (!reset) !(fu_valid[i] && fu_stall[i]));
    a_no_zero_tag: assert property (
      @(posedge clock) disable iff (!reset) !(fu_valid[i] && (fu_tag[i] == '0)));
  end

  // Round-robin scan from rr_ptr using registered FIFO state only; the n-th
  // non-empty FIFO found takes slot n until all slots are used.
  always_comb begin
    int cnt;
    cnt       = 0;
    slot_busy = '0;
    slot_fu   = '0;
    pop       = '0;
    any_win   = 1'b0;
    last_win  = '0;
    idx       = '0;
    for (int k = 0; k < N_FU; k++) begin
      idx = FU_W'((int'(rr_ptr) + k) % N_FU);
      if (!empty[idx] && cnt < N_WAY) begin
        for (int s = 0; s < N_WAY; s++) begin
          if (cnt == s) begin
            slot_busy[s] = 1'b1;
            slot_fu[s]   = idx;
          end
        end
        pop[idx] = !branch_haz;
        any_win  = 1'b1;
        last_win = idx;
        cnt      = cnt + 1;
      end
    end
    rr_next = any_win ? FU_W'((int'(last_win) + 1) % N_FU) : rr_ptr;
  end

  // A flush blanks the CDB for that cycle and the pointer stays put.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           rr_ptr <= '0;
    else if (!branch_haz) rr_ptr <= rr_next;
  end

  // Idle or flushed slots drive all-zero so downstream sees tag 0.
  always_comb begin
    complete_valid    = '0;
    complete_dest_tag = '0;
    complete_value    = '0;
    for (int s = 0; s < N_WAY; s++) begin
      if (slot_busy[s] && !branch_haz) begin
        complete_valid[s]    = 1'b1;
        complete_dest_tag[s] = head[slot_fu[s]][EW-1 -: CDB_BITS];
        complete_value[s]    = head[slot_fu[s]][XLEN-1:0];
      end
    end
  end

`ifdef COMPLETE_PERF_EN
  // Counters wrap freely and hold still during a flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_bcast_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (!branch_haz) begin
      perf_bcast_cnt <= perf_bcast_cnt + 32'($countones(complete_valid));
      if (|(fu_valid & full)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_complete_stage.sv
// Directed testbench for complete_stage with default parameters
// (N_WAY=2, N_FU=4, CDB_BITS=6, XLEN=32, QDEPTH=2).
// Each scenario task drives stimulus and checks hand-computed results.
// Scenario for the optional counters is built only with COMPLETE_PERF_EN.

module tb_complete_stage;

  logic             clock;
  logic             reset;
  logic [3:0]       fu_valid;
  logic [3:0][5:0]  fu_tag;
  logic [3:0][31:0] fu_result;
  logic [3:0]       fu_stall;
  logic             branch_haz;
  logic [1:0]       complete_valid;
  logic [1:0][5:0]  complete_dest_tag;
  logic [1:0][31:0] complete_value;
`ifdef COMPLETE_PERF_EN
  logic [31:0]      perf_bcast_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  int checks;
  int errors;

  complete_stage dut (
    .clock             (clock),
    .reset             (reset),
    .fu_valid          (fu_valid),
    .fu_tag            (fu_tag),
    .fu_result         (fu_result),
    .fu_stall          (fu_stall),
    .branch_haz        (branch_haz),
    .complete_valid    (complete_valid),
    .complete_dest_tag (complete_dest_tag),
    .complete_value    (complete_value)
`ifdef COMPLETE_PERF_EN
    ,
    .perf_bcast_cnt    (perf_bcast_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    fu_valid  = '0;
    fu_tag    = '0;
    fu_result = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    branch_haz = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    branch_haz = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (complete_valid !== 2'b00) begin errors++; $display("FAIL reset_async_valid: got %b expected 00", complete_valid); end
    repeat (3) tick();
    reset = 1'b1;
    #1;
    checks++; if (complete_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", complete_valid); end
    checks++; if (complete_dest_tag !== 12'h000) begin errors++; $display("FAIL reset_tag: got %h expected 000", complete_dest_tag); end
    checks++; if (complete_value !== 64'h0) begin errors++; $display("FAIL reset_value: got %h expected 0", complete_value); end
    checks++; if (fu_stall !== 4'b0000) begin errors++; $display("FAIL reset_stall: got %b expected 0000", fu_stall); end
    fu_valid = 4'b0001; fu_tag[0] = 6'd5; fu_result[0] = 32'hAA;
    tick(); clear_inputs();
    checks++; if (complete_valid !== 2'b01) begin errors++; $display("FAIL single_valid: got %b expected 01", complete_valid); end
    checks++; if (complete_dest_tag !== {6'd0, 6'd5}) begin errors++; $display("FAIL single_tag: got %h expected %h", complete_dest_tag, {6'd0, 6'd5}); end
    checks++; if (complete_value !== {32'h0, 32'hAA}) begin errors++; $display("FAIL single_value: got %h expected %h", complete_value, {32'h0, 32'hAA}); end
    tick();
    checks++; if (complete_valid !== 2'b00) begin errors++; $display("FAIL single_drain: got %b expected 00", complete_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    fu_valid = 4'hF; fu_tag = {6'd4, 6'd3, 6'd2, 6'd1};
    fu_result = {32'h104, 32'h103, 32'h102, 32'h101};
    tick(); clear_inputs();
    checks++; if (complete_valid !== 2'b11) begin errors++; $display("FAIL rr_c1_valid: got %b expected 11", complete_valid); end
    checks++; if (complete_dest_tag !== {6'd2, 6'd1}) begin errors++; $display("FAIL rr_c1_tag: got %h expected %h", complete_dest_tag, {6'd2, 6'd1}); end
    checks++; if (complete_value !== {32'h102, 32'h101}) begin errors++; $display("FAIL rr_c1_value: got %h expected %h", complete_value, {32'h102, 32'h101}); end
    tick();
    checks++; if (complete_dest_tag !== {6'd4, 6'd3}) begin errors++; $display("FAIL rr_c2_tag: got %h expected %h", complete_dest_tag, {6'd4, 6'd3}); end
    checks++; if (complete_value !== {32'h104, 32'h103}) begin errors++; $display("FAIL rr_c2_value: got %h expected %h", complete_value, {32'h104, 32'h103}); end
    tick();
    checks++; if (complete_valid !== 2'b00) begin errors++; $display("FAIL rr_drain: got %b expected 00", complete_valid); end
    // rr_ptr is back at 0, so FU0 and FU1 win first again.
    fu_valid = 4'hF; fu_tag = {6'd14, 6'd13, 6'd12, 6'd11};
    tick(); clear_inputs();
    checks++; if (complete_dest_tag !== {6'd12, 6'd11}) begin errors++; $display("FAIL rr_wrap_c1: got %h expected %h", complete_dest_tag, {6'd12, 6'd11}); end
    tick();
    checks++; if (complete_dest_tag !== {6'd14, 6'd13}) begin errors++; $display("FAIL rr_wrap_c2: got %h expected %h", complete_dest_tag, {6'd14, 6'd13}); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    fu_valid = 4'b0011; fu_tag = {6'd0, 6'd0, 6'd51, 6'd50};
    fu_result = {32'h0, 32'h0, 32'h51, 32'h50};
    tick(); clear_inputs();
    checks++; if (complete_dest_tag !== {6'd51, 6'd50}) begin errors++; $display("FAIL b2b_c1_tag: got %h expected %h", complete_dest_tag, {6'd51, 6'd50}); end
    fu_valid = 4'b0111; fu_tag = {6'd0, 6'd31, 6'd21, 6'd52};
    fu_result = {32'h0, 32'h31, 32'h21, 32'h52};
    tick(); clear_inputs();
    checks++; if (complete_dest_tag !== {6'd52, 6'd31}) begin errors++; $display("FAIL b2b_c2_tag: got %h expected %h", complete_dest_tag, {6'd52, 6'd31}); end
    checks++; if (fu_stall !== 4'b0000) begin errors++; $display("FAIL b2b_c2_stall: got %b expected 0000", fu_stall); end
    fu_valid = 4'b0010; fu_tag[1] = 6'd22; fu_result[1] = 32'h22;
    tick(); clear_inputs();
    checks++; if (fu_stall !== 4'b0010) begin errors++; $display("FAIL b2b_full_stall: got %b expected 0010", fu_stall); end
    checks++; if (complete_dest_tag !== {6'd0, 6'd21}) begin errors++; $display("FAIL b2b_c3_tag: got %h expected %h", complete_dest_tag, {6'd0, 6'd21}); end
    checks++; if (complete_value !== {32'h0, 32'h21}) begin errors++; $display("FAIL b2b_c3_value: got %h expected %h", complete_value, {32'h0, 32'h21}); end
    tick();
    checks++; if (fu_stall !== 4'b0000) begin errors++; $display("FAIL b2b_unstall: got %b expected 0000", fu_stall); end
    checks++; if (complete_dest_tag !== {6'd0, 6'd22}) begin errors++; $display("FAIL b2b_c4_tag: got %h expected %h", complete_dest_tag, {6'd0, 6'd22}); end
    fu_valid = 4'b0010; fu_tag[1] = 6'd23; fu_result[1] = 32'h23;
    tick(); clear_inputs();
    checks++; if (complete_dest_tag !== {6'd0, 6'd23}) begin errors++; $display("FAIL b2b_c5_tag: got %h expected %h", complete_dest_tag, {6'd0, 6'd23}); end
    tick();
    checks++; if (complete_valid !== 2'b00) begin errors++; $display("FAIL b2b_drain: got %b expected 00", complete_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    fu_valid = 4'hF; fu_tag = {6'd4, 6'd3, 6'd2, 6'd1};
    tick(); clear_inputs();
    fu_valid = 4'b0111; fu_tag = {6'd0, 6'd7, 6'd6, 6'd5};
    tick(); clear_inputs();
    // Five entries buffered; flush this cycle and try a push that must be dropped.
    branch_haz = 1'b1;
    fu_valid = 4'b1000; fu_tag[3] = 6'd33; fu_result[3] = 32'h33;
    #1;
    checks++; if (complete_valid !== 2'b00) begin errors++; $display("FAIL flush_valid: got %b expected 00", complete_valid); end
    checks++; if (complete_dest_tag !== 12'h000) begin errors++; $display("FAIL flush_tag: got %h expected 000", complete_dest_tag); end
    checks++; if (complete_value !== 64'h0) begin errors++; $display("FAIL flush_value: got %h expected 0", complete_value); end
    checks++; if (fu_stall !== 4'b0100) begin errors++; $display("FAIL flush_stall_held: got %b expected 0100", fu_stall); end
    tick(); clear_inputs(); branch_haz = 1'b0;
    #1;
    checks++; if (complete_valid !== 2'b00) begin errors++; $display("FAIL post_flush_valid: got %b expected 00", complete_valid); end
    checks++; if (fu_stall !== 4'b0000) begin errors++; $display("FAIL post_flush_stall: got %b expected 0000", fu_stall); end
    // rr_ptr kept at 2 across the flush: FU3 is scanned before FU0.
    fu_valid = 4'b1001; fu_tag = {6'd9, 6'd0, 6'd0, 6'd8};
    fu_result = {32'h9, 32'h0, 32'h0, 32'h8};
    tick(); clear_inputs();
    checks++; if (complete_dest_tag !== {6'd8, 6'd9}) begin errors++; $display("FAIL post_flush_tag: got %h expected %h", complete_dest_tag, {6'd8, 6'd9}); end
    checks++; if (complete_value !== {32'h8, 32'h9}) begin errors++; $display("FAIL post_flush_value: got %h expected %h", complete_value, {32'h8, 32'h9}); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    fu_valid = 4'hF; fu_tag = {6'd4, 6'd3, 6'd2, 6'd1};
    tick(); clear_inputs();
    fu_valid = 4'hF; fu_tag = {6'd8, 6'd7, 6'd6, 6'd5};
    tick(); clear_inputs();
    checks++; if (fu_stall !== 4'b1100) begin errors++; $display("FAIL areset_pre_stall: got %b expected 1100", fu_stall); end
    checks++; if (complete_dest_tag !== {6'd4, 6'd3}) begin errors++; $display("FAIL areset_pre_tag: got %h expected %h", complete_dest_tag, {6'd4, 6'd3}); end
    #2 reset = 1'b0;
    #1;
    checks++; if (complete_valid !== 2'b00) begin errors++; $display("FAIL areset_valid: got %b expected 00", complete_valid); end
    checks++; if (complete_dest_tag !== 12'h000) begin errors++; $display("FAIL areset_tag: got %h expected 000", complete_dest_tag); end
    checks++; if (fu_stall !== 4'b0000) begin errors++; $display("FAIL areset_stall: got %b expected 0000", fu_stall); end
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++; if (complete_valid !== 2'b00) begin errors++; $display("FAIL areset_release: got %b expected 00", complete_valid); end
    tick();
    checks++; if (complete_dest_tag !== 12'h000) begin errors++; $display("FAIL areset_stale: got %h expected 000", complete_dest_tag); end
  endtask

`ifdef COMPLETE_PERF_EN
  task automatic test_perf();
    do_reset();
    checks++; if (perf_bcast_cnt !== 32'd0) begin errors++; $display("FAIL perf_bcast_reset: got %0d expected 0", perf_bcast_cnt); end
    // Each round: six broadcasts and exactly one cycle of stalled fu_valid.
    for (int r = 0; r < 3; r++) begin
      fu_valid = 4'hF; fu_tag = {6'd4, 6'd3, 6'd2, 6'd1};
      tick(); clear_inputs();
      fu_valid = 4'b1100; fu_tag = {6'd6, 6'd5, 6'd0, 6'd0};
      tick(); clear_inputs();
      fu_valid = 4'b0100; fu_tag[2] = 6'd7;
      tick(); clear_inputs();
      tick(); tick();
    end
    checks++; if (perf_bcast_cnt !== 32'd18) begin errors++; $display("FAIL perf_bcast: got %0d expected 18", perf_bcast_cnt); end
    checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    branch_haz = 1'b0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef COMPLETE_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
